// File: rtl/ascon_pack.sv
// Shared ASCON definitions: permutation state, FSM encoding, constants and the
// round-function building blocks used by both the encryption and decryption tops.
package ascon_pack;

  typedef logic [4:0][63:0] state_t;

  typedef enum logic [3:0] {
    IDLE, INIT, WAIT_AD, AD, WAIT_CT, CT, WAIT_LAST, FINAL, DONE
  } fsm_t;

  localparam logic [63:0] ASCON_IV   = 64'h80400c0600000000;
  localparam logic [3:0]  PA_ROUNDS  = 4'd12;
  localparam logic [3:0]  PB_ROUNDS  = 4'd6;
  localparam logic [3:0]  LAST_ROUND = PA_ROUNDS - 4'd1;
  localparam logic [3:0]  PB_FIRST   = PA_ROUNDS - PB_ROUNDS;

  function automatic logic [7:0] round_const(input logic [3:0] i);
    return {~i, i};
  endfunction

  function automatic logic [63:0] rotr(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // Bit-sliced 5-bit S-box applied to all 64 columns at once.
  function automatic state_t sub_layer(input state_t s);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    state_t r;
    x0 = s[0]; x1 = s[1]; x2 = s[2]; x3 = s[3]; x4 = s[4];
    x0 ^= x4; x4 ^= x3; x2 ^= x1;
    t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
    x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
    x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
    r[0] = x0; r[1] = x1; r[2] = x2; r[3] = x3; r[4] = x4;
    return r;
  endfunction

  function automatic state_t lin_layer(input state_t s);
    state_t r;
    r[0] = s[0] ^ rotr(s[0], 19) ^ rotr(s[0], 28);
    r[1] = s[1] ^ rotr(s[1], 61) ^ rotr(s[1], 39);
    r[2] = s[2] ^ rotr(s[2], 1)  ^ rotr(s[2], 6);
    r[3] = s[3] ^ rotr(s[3], 10) ^ rotr(s[3], 17);
    r[4] = s[4] ^ rotr(s[4], 7)  ^ rotr(s[4], 41);
    return r;
  endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational ASCON permutation round: constant addition, substitution
// layer and linear diffusion layer for round index rnd (0..11).
module ascon_round
  import ascon_pack::*;
(
  input  state_t     s_in,
  input  logic [3:0] rnd,
  output state_t     s_out
);

  state_t s_c;

  always_comb begin
    s_c    = s_in;
    s_c[2] = s_in[2] ^ {56'd0, round_const(rnd)};
    s_out  = lin_layer(sub_layer(s_c));
  end

endmodule

// File: rtl/ascon_dec_top.sv
// ASCON-128 authenticated decryption: one AD block, N_CT ciphertext blocks, tag out.
// Optional internal tag comparison against tag_ref_s when ASCON_DEC_TAGCHK_EN is defined.
module ascon_dec_top
  import ascon_pack::*;
#(
  parameter int unsigned N_CT       = 4,
  parameter int unsigned LAST_BYTES = 7
) (
  input  logic         clock_s,
  input  logic         resetb_s,
  input  logic         start_s,
  input  logic [63:0]  data_s,
  input  logic         data_valid_s,
  input  logic [127:0] key_s,
  input  logic [127:0] nonce_s,
  input  logic [127:0] tag_ref_s,
  output logic [63:0]  plain_s,
  output logic         plain_valid_s,
  output logic [127:0] tag_s,
  output logic         auth_ok_s,
  output logic         end_s
);

  localparam logic [63:0] LAST_MASK = ~(64'hFFFF_FFFF_FFFF_FFFF >> (8 * LAST_BYTES));
  localparam logic [63:0] PAD_BIT   = 64'h80 << (8 * (7 - LAST_BYTES));

  fsm_t        fsm;
  state_t      st;
  state_t      rnd_out;
  logic [3:0]  rnd;
  logic [3:0]  blk;
  logic [127:0] tag_next;

  ascon_round u_round (
    .s_in  (st),
    .rnd   (rnd),
    .s_out (rnd_out)
  );

  assign tag_next = {rnd_out[3] ^ key_s[127:64], rnd_out[4] ^ key_s[63:0]};

`ifdef ASCON_DEC_TAGCHK_EN
  logic auth_q;
  assign auth_ok_s = auth_q;
`else
  logic unused_tag_ref;
  assign unused_tag_ref = ^tag_ref_s;
  assign auth_ok_s      = 1'b0;
`endif

  always_ff @(posedge clock_s) begin
    if (!resetb_s) begin
      fsm           <= IDLE;
      st            <= '0;
      rnd           <= '0;
      blk           <= '0;
      plain_s       <= '0;
      plain_valid_s <= 1'b0;
      tag_s         <= '0;
      end_s         <= 1'b0;
`ifdef ASCON_DEC_TAGCHK_EN
      auth_q        <= 1'b0;
`endif
    end else begin
      plain_valid_s <= 1'b0;
      unique case (fsm)
        IDLE, DONE: begin
          if (start_s) begin
            st[0] <= ASCON_IV;
            st[1] <= key_s[127:64];
            st[2] <= key_s[63:0];
            st[3] <= nonce_s[127:64];
            st[4] <= nonce_s[63:0];
            rnd   <= '0;
            blk   <= '0;
            tag_s <= '0;
            end_s <= 1'b0;
`ifdef ASCON_DEC_TAGCHK_EN
            auth_q <= 1'b0;
`endif
            fsm   <= INIT;
          end
        end
        INIT: begin
          st <= rnd_out;
          if (rnd == LAST_ROUND) begin
            st[3] <= rnd_out[3] ^ key_s[127:64];
            st[4] <= rnd_out[4] ^ key_s[63:0];
            fsm   <= WAIT_AD;
          end else begin
            rnd <= rnd + 4'd1;
          end
        end
        WAIT_AD: begin
          if (data_valid_s) begin
            st[0] <= st[0] ^ data_s;
            rnd   <= PB_FIRST;
            fsm   <= AD;
          end
        end
        AD: begin
          st <= rnd_out;
          if (rnd == LAST_ROUND) begin
            st[4] <= rnd_out[4] ^ 64'd1;
            fsm   <= (N_CT == 1) ? WAIT_LAST : WAIT_CT;
          end else begin
            rnd <= rnd + 4'd1;
          end
        end
        WAIT_CT: begin
          if (data_valid_s) begin
            plain_s       <= st[0] ^ data_s;
            plain_valid_s <= 1'b1;
            st[0]         <= data_s;
            blk           <= blk + 4'd1;
            rnd           <= PB_FIRST;
            fsm           <= CT;
          end
        end
        CT: begin
          st <= rnd_out;
          if (rnd == LAST_ROUND) begin
            fsm <= (blk == 4'(N_CT - 1)) ? WAIT_LAST : WAIT_CT;
          end else begin
            rnd <= rnd + 4'd1;
          end
        end
        WAIT_LAST: begin
          if (data_valid_s) begin
            plain_s       <= (st[0] ^ data_s) & LAST_MASK;
            plain_valid_s <= 1'b1;
            // Ciphertext bytes replace the rate; the untouched tail keeps the keystream plus padding.
            st[0]         <= (data_s & LAST_MASK) | ((st[0] ^ PAD_BIT) & ~LAST_MASK);
            st[1]         <= st[1] ^ key_s[127:64];
            st[2]         <= st[2] ^ key_s[63:0];
            rnd           <= '0;
            fsm           <= FINAL;
          end
        end
        FINAL: begin
          st <= rnd_out;
          if (rnd == LAST_ROUND) begin
            tag_s <= tag_next;
            end_s <= 1'b1;
`ifdef ASCON_DEC_TAGCHK_EN
            auth_q <= (tag_next == tag_ref_s);
`endif
            fsm   <= DONE;
          end else begin
            rnd <= rnd + 4'd1;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ascon_dec_top.sv
// Directed bench for ascon_dec_top: loopback against a table-driven ASCON model,
// corrupted ciphertext, ignored valids, mid-run reset and restart from DONE.
module tb_ascon_dec_top;

  localparam logic [127:0] KEY   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] NONCE = 128'h00112233445566778899aabbccddeeff;
  localparam logic [63:0]  AD_BLK = 64'h3230323380000000;
  localparam logic [63:0]  IV     = 64'h80400c0600000000;
  localparam logic [63:0]  MASK7  = 64'hffffffffffffff00;

  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

  logic         clock_s;
  logic         resetb_s;
  logic         start_s;
  logic [63:0]  data_s;
  logic         data_valid_s;
  logic [127:0] key_s;
  logic [127:0] nonce_s;
  logic [127:0] tag_ref_s;
  logic [63:0]  plain_s;
  logic         plain_valid_s;
  logic [127:0] tag_s;
  logic         auth_ok_s;
  logic         end_s;

  ascon_dec_top #(.N_CT(4), .LAST_BYTES(7)) dut (
    .clock_s       (clock_s),
    .resetb_s      (resetb_s),
    .start_s       (start_s),
    .data_s        (data_s),
    .data_valid_s  (data_valid_s),
    .key_s         (key_s),
    .nonce_s       (nonce_s),
    .tag_ref_s     (tag_ref_s),
    .plain_s       (plain_s),
    .plain_valid_s (plain_valid_s),
    .tag_s         (tag_s),
    .auth_ok_s     (auth_ok_s),
    .end_s         (end_s)
  );

  initial clock_s = 1'b0;
  always #5 clock_s = ~clock_s;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0]  pt_ref   [4];
  logic [63:0]  pt_exp   [4];
  logic [63:0]  ct_clean [4];
  logic [63:0]  ct_in    [4];
  logic [63:0]  pt_mod   [4];
  logic [127:0] tag_clean;
  logic [127:0] tag_mod;
  logic         exp_auth;
  logic [63:0]  mx [5];
  logic [63:0]  pt_q [$];

  always @(negedge clock_s) if (plain_valid_s) pt_q.push_back(plain_s);

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock_s);
    #1;
  endtask

  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  task automatic m_round(input int r);
    logic [63:0] y [5];
    logic [4:0]  v;
    mx[2] = mx[2] ^ 64'(((15 - r) << 4) | r);
    for (int b = 0; b < 64; b++) begin
      v = {mx[0][b], mx[1][b], mx[2][b], mx[3][b], mx[4][b]};
      v = SBOX[v];
      y[0][b] = v[4]; y[1][b] = v[3]; y[2][b] = v[2]; y[3][b] = v[1]; y[4][b] = v[0];
    end
    mx[0] = y[0] ^ ror(y[0], 19) ^ ror(y[0], 28);
    mx[1] = y[1] ^ ror(y[1], 61) ^ ror(y[1], 39);
    mx[2] = y[2] ^ ror(y[2], 1)  ^ ror(y[2], 6);
    mx[3] = y[3] ^ ror(y[3], 10) ^ ror(y[3], 17);
    mx[4] = y[4] ^ ror(y[4], 7)  ^ ror(y[4], 41);
  endtask

  task automatic m_perm(input int first);
    for (int r = first; r < 12; r++) m_round(r);
  endtask

  task automatic m_init_ad();
    mx[0] = IV; mx[1] = KEY[127:64]; mx[2] = KEY[63:0];
    mx[3] = NONCE[127:64]; mx[4] = NONCE[63:0];
    m_perm(0);
    mx[3] ^= KEY[127:64]; mx[4] ^= KEY[63:0];
    mx[0] ^= AD_BLK;
    m_perm(6);
    mx[4] ^= 64'd1;
  endtask

  task automatic m_final(output logic [127:0] tag);
    mx[1] ^= KEY[127:64]; mx[2] ^= KEY[63:0];
    m_perm(0);
    tag = {mx[3] ^ KEY[127:64], mx[4] ^ KEY[63:0]};
  endtask

  task automatic m_encrypt();
    m_init_ad();
    for (int j = 0; j < 3; j++) begin
      ct_clean[j] = mx[0] ^ pt_ref[j];
      mx[0] = ct_clean[j];
      m_perm(6);
    end
    mx[0] ^= pt_ref[3];
    ct_clean[3] = mx[0];
    m_final(tag_clean);
  endtask

  task automatic m_decrypt();
    m_init_ad();
    for (int j = 0; j < 3; j++) begin
      pt_mod[j] = mx[0] ^ ct_in[j];
      mx[0] = ct_in[j];
      m_perm(6);
    end
    pt_mod[3] = (mx[0] ^ ct_in[3]) & MASK7;
    mx[0] = (ct_in[3] & MASK7) | ((mx[0] ^ 64'h80) & ~MASK7);
    m_final(tag_mod);
  endtask

  task automatic send(input logic [63:0] d);
    data_s = d;
    data_valid_s = 1'b1;
    tick();
    data_valid_s = 1'b0;
    data_s = {$urandom, $urandom};
  endtask

  // noise: stray valids inside INIT/CT rounds; abort: reset 3 cycles into FINAL;
  // vstart: valid alongside the start pulse.
  task automatic run_dec(input string name, input bit noise, input bit abort, input bit vstart,
                         input logic [127:0] exp_tag, input logic exp_ok);
    int base;
    int lat;
    logic [63:0] got;
    base = pt_q.size();
    start_s = 1'b1;
    if (vstart) begin
      data_s = AD_BLK;
      data_valid_s = 1'b1;
    end
    tick();
    start_s = 1'b0;
    data_valid_s = 1'b0;
    check({name, "_end_low_after_start"}, end_s, 1'b0);
    check({name, "_auth_low_after_start"}, auth_ok_s, 1'b0);
    for (int i = 0; i < 12; i++) begin
      data_valid_s = noise && (i == 4);
      data_s = 64'hdeadbeefcafef00d;
      tick();
    end
    data_valid_s = 1'b0;
    send(AD_BLK);
    repeat (6) tick();
    for (int b = 0; b < 4; b++) begin
      send(ct_in[b]);
      if (b < 3) begin
        for (int i = 0; i < 6; i++) begin
          data_valid_s = noise && (i == 2);
          data_s = 64'h0123456789abcdef;
          tick();
        end
        data_valid_s = 1'b0;
      end
    end
    if (abort) begin
      repeat (3) tick();
      resetb_s = 1'b0;
      repeat (3) tick();
      check({name, "_rst_end"}, end_s, 1'b0);
      check({name, "_rst_tag"}, tag_s, '0);
      check({name, "_rst_plain"}, plain_s, '0);
      resetb_s = 1'b1;
      repeat (3) tick();
      check({name, "_no_stale_end"}, end_s, 1'b0);
      check({name, "_plain_count"}, pt_q.size() - base, 4);
      return;
    end
    lat = 0;
    while (!end_s && lat < 40) begin
      tick();
      lat++;
    end
    check({name, "_end_latency"}, lat, 12);
    check({name, "_plain_count"}, pt_q.size() - base, 4);
    for (int i = 0; i < 4; i++) begin
      got = (base + i < pt_q.size()) ? pt_q[base + i] : '0;
      check($sformatf("%s_pt%0d", name, i), got, pt_exp[i]);
    end
    check({name, "_tag"}, tag_s, exp_tag);
    check({name, "_auth"}, auth_ok_s, exp_ok);
    tick();
    check({name, "_end_held"}, end_s, 1'b1);
  endtask

  initial begin
    pt_ref[0] = 64'h436f6e636576657a;
    pt_ref[1] = 64'h204153434f4e2065;
    pt_ref[2] = 64'h6e2053797374656d;
    pt_ref[3] = 64'h566572696c6f6780;
`ifdef ASCON_DEC_TAGCHK_EN
    exp_auth = 1'b1;
`else
    exp_auth = 1'b0;
`endif

    resetb_s = 1'b0;
    for (int i = 0; i < 5; i++) begin
      start_s      = 1'($urandom_range(0, 1));
      data_valid_s = 1'($urandom_range(0, 1));
      data_s       = {$urandom, $urandom};
      key_s        = {$urandom, $urandom, $urandom, $urandom};
      nonce_s      = {$urandom, $urandom, $urandom, $urandom};
      tag_ref_s    = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    check("rst_plain", plain_s, '0);
    check("rst_plain_valid", plain_valid_s, 1'b0);
    check("rst_tag", tag_s, '0);
    check("rst_auth", auth_ok_s, 1'b0);
    check("rst_end", end_s, 1'b0);
    resetb_s = 1'b1;
    start_s = 1'b0;
    data_valid_s = 1'b0;
    key_s = KEY;
    nonce_s = NONCE;
    data_s = 64'h5555aaaa5555aaaa;
    data_valid_s = 1'b1;
    repeat (20) tick();
    data_valid_s = 1'b0;
    check("idle_end", end_s, 1'b0);
    check("idle_no_plain", pt_q.size(), 0);

    m_encrypt();
    tag_ref_s = tag_clean;
    for (int i = 0; i < 4; i++) ct_in[i] = ct_clean[i];
    pt_exp[0] = pt_ref[0];
    pt_exp[1] = pt_ref[1];
    pt_exp[2] = pt_ref[2];
    pt_exp[3] = 64'h566572696c6f6700;

    run_dec("clean", 1'b0, 1'b0, 1'b0, tag_clean, exp_auth);
    run_dec("restart", 1'b0, 1'b0, 1'b1, tag_clean, exp_auth);

    ct_in[2] = ct_clean[2] ^ 64'd1;
    m_decrypt();
    pt_exp[2] = 64'h6e2053797374656c;
    pt_exp[3] = pt_mod[3];
    run_dec("corrupt", 1'b0, 1'b0, 1'b0, tag_mod, 1'b0);
    check("corrupt_tag_differs", tag_s != tag_clean, 1'b1);
    ct_in[2] = ct_clean[2];
    pt_exp[2] = pt_ref[2];
    pt_exp[3] = 64'h566572696c6f6700;

    run_dec("noise", 1'b1, 1'b0, 1'b0, tag_clean, exp_auth);
    run_dec("abort", 1'b0, 1'b1, 1'b0, tag_clean, exp_auth);
    run_dec("after_abort", 1'b0, 1'b0, 1'b0, tag_clean, exp_auth);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
